uart_rx: RTL

Serial receiver for the UART subsystem; directly upstream of the RX FIFO. Oversamples the asynchronous `rx` line with the shared baud-rate tick, reassembles LSB-first frames, and presents each word with a one-cycle `rx_done` pulse wired to the FIFO `wr` input. Framing and, optionally, parity errors are flagged alongside each word.

---
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_rx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: line/tick inputs and word/status outputs of the UART receiver.
// master = receiver side (drives word and flags), slave = consumer/line side.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 s_tick;
  logic [DATA_BITS-1:0] dout;
  logic                 rx_done;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    input  rx, s_tick,
    output dout, rx_done, frame_err, parity_err, busy
  );

  modport slave (
    output rx, s_tick,
    input  dout, rx_done, frame_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver, LSB-first frames, one-cycle rx_done
// per frame with framing/parity flags. Optional even parity bit: UART_PARITY_EN.
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int SB_TICKS  = 16
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.master bus
);

  localparam int NW = $clog2(DATA_BITS);
  // Tick counter widens beyond 4 bits only when the stop period needs it (2 stop bits).
  localparam int SW = (SB_TICKS > 16) ? $clog2(SB_TICKS) : 4;

  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);
  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_sync_q;
  logic [SW-1:0]        s_cnt_q, s_cnt_d;
  logic [NW-1:0]        n_cnt_q, n_cnt_d;
  logic [DATA_BITS-1:0] b_reg_q, b_reg_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 rx_done_q, rx_done_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
`ifdef UART_PARITY_EN
  logic                 par_q, par_d;
`endif

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      s_cnt_q      <= '0;
      n_cnt_q      <= '0;
      b_reg_q      <= '0;
      dout_q       <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef UART_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= bus.rx;
      rx_sync_q    <= rx_meta_q;
      s_cnt_q      <= s_cnt_d;
      n_cnt_q      <= n_cnt_d;
      b_reg_q      <= b_reg_d;
      dout_q       <= dout_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
`ifdef UART_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  // Next-state logic: frame sequencing and word/flag capture at the stop sample.
  always_comb begin
    state_d      = state_q;
    s_cnt_d      = s_cnt_q;
    n_cnt_d      = n_cnt_q;
    b_reg_d      = b_reg_q;
    dout_d       = dout_q;
    rx_done_d    = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
`ifdef UART_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s_cnt_q == S_MID) begin
            if (!rx_sync_q) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_cnt_q == S_BIT) begin
            b_reg_d = {rx_sync_q, b_reg_q[DATA_BITS-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == N_LAST) begin
`ifdef UART_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (bus.s_tick) begin
          if (s_cnt_q == S_BIT) begin
            par_d   = rx_sync_q;
            s_cnt_d = '0;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (bus.s_tick) begin
          if (s_cnt_q == S_STOP) begin
            dout_d      = b_reg_q;
            rx_done_d   = 1'b1;
            frame_err_d = ~rx_sync_q;
`ifdef UART_PARITY_EN
            parity_err_d = ^{b_reg_q, par_q};
`endif
            s_cnt_d     = '0;
            state_d     = rx_sync_q ? IDLE : BREAK;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dout       = dout_q;
  assign bus.rx_done    = rx_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
